serial_tx_scheduler: RTL



---
 rtl/serial_tx_scheduler.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: shares one dual-lane bit-serial buffer among NUM_REQ requesters, timing load, shift window and gap.
// Build option: SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module serial_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_W     = 128,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WORD_W-1:0]  word_1,
    input  logic [NUM_REQ*WORD_W-1:0]  word_2,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WORD_W-1:0]          buf_in_1,
    output logic [WORD_W-1:0]          buf_in_2,
    output logic                       buf_send,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       tx_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WORD_W + 1);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(WORD_W - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gap_cnt;
    logic [IW-1:0] win;

`ifdef SCHED_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[IW'(i)]) win = IW'(i);
    end
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    // Scan offsets high to low so the smallest offset from ptr is written last and wins.
    always_comb begin
        win = ptr;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) win = idx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack      <= '0;
            buf_send <= 1'b0;
            tx_done  <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            buf_in_1 <= '0;
            buf_in_2 <= '0;
            cnt      <= '0;
            gap_cnt  <= '0;
`ifndef SCHED_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            ack      <= '0;
            buf_send <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    state    <= LOAD;
                    busy     <= 1'b1;
                    ack      <= NUM_REQ'(1) << win;
                    buf_send <= 1'b1;
                    grant_id <= win;
                    buf_in_1 <= WORD_W'(word_1 >> (int'(win) * WORD_W));
                    buf_in_2 <= WORD_W'(word_2 >> (int'(win) * WORD_W));
`ifndef SCHED_FIXED_PRIO_EN
                    ptr      <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
                end
                LOAD: begin
                    state   <= SHIFT;
                    cnt     <= '0;
                    tx_done <= WORD_W == 1;
                end
                SHIFT: if (cnt == CNT_LAST) begin
                    state   <= GAP_CYCLES == 0 ? IDLE : GAP;
                    busy    <= GAP_CYCLES != 0;
                    gap_cnt <= '0;
                end else begin
                    cnt     <= cnt + 1'b1;
                    tx_done <= cnt == CNT_PRE;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
